// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage for a 16-bit pipeline. It issues one read at a time
// to the instruction memory, loads the returned word into the IF/ID pipeline
// register, and honours stalls (PCWrite / IFIDWrite) and flushes
// (redirect_valid) from later stages.
//
// A word that comes back while the pipeline is stalled is parked in an
// internal buffer (S_HOLD) so the memory does not have to be asked again.
// A redirect that arrives while a read is still outstanding sends the FSM to
// S_DRAIN. There it waits for the stale response, throws it away, and only
// then issues a read at the new PC.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   reset_n        : asynchronous active-low reset
//   PCWrite        : 1 = freeze PC (stall)
//   IFIDWrite      : 1 = freeze IF/ID register (stall)
//   redirect_valid : resolved branch/jump, flush fetch
//   redirect_pc    : redirect target
//   i_readM        : instruction memory read request
//   i_address      : instruction memory read address
//   i_data         : instruction memory read data (valid while i_ready = 1)
//   i_ready        : instruction memory response strobe
//   IFID_inst      : IF/ID instruction
//   IFID_pc        : IF/ID address of the instruction
//   IFID_next_pc   : IF/ID sequential successor address
//   IFID_valid     : IF/ID holds a real instruction (0 = bubble)
//   fetch_busy     : 1 = no instruction delivered into IF/ID this cycle
//   num_fetch      : count of instructions loaded into IF/ID (wraps)
// ---------------------------------------------------------------------------
module fetch_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        PCWrite,
    input  logic        IFIDWrite,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        i_readM,
    output logic [15:0] i_address,
    input  logic [15:0] i_data,
    input  logic        i_ready,
    output logic [15:0] IFID_inst,
    output logic [15:0] IFID_pc,
    output logic [15:0] IFID_next_pc,
    output logic        IFID_valid,
    output logic        fetch_busy,
    output logic [15:0] num_fetch
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]  state_reg, state_next;
    logic [15:0] pc_reg, pc_next;
    logic [15:0] req_addr_reg, req_addr_next;
    logic [15:0] buf_reg, buf_next;
    logic [15:0] ifid_inst_reg, ifid_inst_next;
    logic [15:0] ifid_pc_reg, ifid_pc_next;
    logic [15:0] ifid_next_pc_reg, ifid_next_pc_next;
    logic        ifid_valid_reg, ifid_valid_next;
    logic [15:0] num_fetch_reg, num_fetch_next;

    logic        hold;
    logic        load_ifid;
    logic [15:0] load_data;

    assign hold = PCWrite | IFIDWrite;

    always_comb begin
        state_next        = state_reg;
        pc_next           = pc_reg;
        buf_next          = buf_reg;
        ifid_inst_next    = ifid_inst_reg;
        ifid_pc_next      = ifid_pc_reg;
        ifid_next_pc_next = ifid_next_pc_reg;
        ifid_valid_next   = ifid_valid_reg;
        num_fetch_next    = num_fetch_reg;
        load_ifid         = 1'b0;
        load_data         = i_data;

        if (redirect_valid) begin
            // Flush has priority over stalls and over any returning data.
            pc_next         = redirect_pc;
            ifid_valid_next = 1'b0;
            buf_next        = 16'h0000;
            case (state_reg)
                S_REQ, S_WAIT: state_next = i_ready ? S_REQ : S_DRAIN;
                S_HOLD:        state_next = S_REQ;
                default:       state_next = S_DRAIN;
            endcase
        end else begin
            case (state_reg)
                S_REQ, S_WAIT: begin
                    if (i_ready) begin
                        if (hold) begin
                            buf_next   = i_data;
                            state_next = S_HOLD;
                        end else begin
                            load_ifid  = 1'b1;
                            load_data  = i_data;
                            state_next = S_REQ;
                        end
                    end else begin
                        state_next = S_WAIT;
                        if (!IFIDWrite) begin
                            ifid_valid_next = 1'b0;
                        end
                    end
                end
                S_HOLD: begin
                    if (!hold) begin
                        load_ifid  = 1'b1;
                        load_data  = buf_reg;
                        state_next = S_REQ;
                    end
                end
                default: begin
                    // S_DRAIN: the response belongs to the abandoned address.
                    if (i_ready) begin
                        state_next = S_REQ;
                    end
                end
            endcase
        end

        if (load_ifid) begin
            ifid_inst_next    = load_data;
            ifid_pc_next      = req_addr_reg;
            ifid_next_pc_next = req_addr_reg + 16'd1;
            ifid_valid_next   = 1'b1;
            pc_next           = pc_reg + 16'd1;
            num_fetch_next    = num_fetch_reg + 16'd1;
        end

        // The request address is captured only when a new request starts,
        // so it stays put while waiting, holding or draining.
        req_addr_next = (state_next == S_REQ) ? pc_next : req_addr_reg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= S_REQ;
            pc_reg           <= 16'h0000;
            req_addr_reg     <= 16'h0000;
            buf_reg          <= 16'h0000;
            ifid_inst_reg    <= 16'h0000;
            ifid_pc_reg      <= 16'h0000;
            ifid_next_pc_reg <= 16'h0000;
            ifid_valid_reg   <= 1'b0;
            num_fetch_reg    <= 16'h0000;
        end else begin
            state_reg        <= state_next;
            pc_reg           <= pc_next;
            req_addr_reg     <= req_addr_next;
            buf_reg          <= buf_next;
            ifid_inst_reg    <= ifid_inst_next;
            ifid_pc_reg      <= ifid_pc_next;
            ifid_next_pc_reg <= ifid_next_pc_next;
            ifid_valid_reg   <= ifid_valid_next;
            num_fetch_reg    <= num_fetch_next;
        end
    end

    assign i_readM      = (state_reg != S_HOLD);
    assign i_address    = req_addr_reg;
    assign IFID_inst    = ifid_inst_reg;
    assign IFID_pc      = ifid_pc_reg;
    assign IFID_next_pc = ifid_next_pc_reg;
    assign IFID_valid   = ifid_valid_reg;
    assign fetch_busy   = ~load_ifid;
    assign num_fetch    = num_fetch_reg;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        i_readM;
    logic [15:0] i_address;
    logic [15:0] i_data;
    logic        i_ready;
    logic [15:0] IFID_inst;
    logic [15:0] IFID_pc;
    logic [15:0] IFID_next_pc;
    logic        IFID_valid;
    logic        fetch_busy;
    logic [15:0] num_fetch;

    typedef struct {
        logic [15:0] inst;
        logic [15:0] pc;
        logic [15:0] npc;
    } fetch_t;

    fetch_t      exp_q[$];
    fetch_t      last_exp;
    int          checks;
    int          errors;
    int          exp_cnt;
    int          wait_cnt;
    int          mem_lat;
    logic [15:0] salt;

    fetch_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .PCWrite        (PCWrite),
        .IFIDWrite      (IFIDWrite),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .i_readM        (i_readM),
        .i_address      (i_address),
        .i_data         (i_data),
        .i_ready        (i_ready),
        .IFID_inst      (IFID_inst),
        .IFID_pc        (IFID_pc),
        .IFID_next_pc   (IFID_next_pc),
        .IFID_valid     (IFID_valid),
        .fetch_busy     (fetch_busy),
        .num_fetch      (num_fetch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'd3) ^ 16'h5A5A;
    endfunction

    // Instruction memory: answers after mem_lat extra waiting cycles.
    assign i_data  = mem_word(i_address) ^ salt;
    assign i_ready = reset_n && i_readM && (wait_cnt >= mem_lat);

    function automatic void push_exp(input logic [15:0] pc, input logic [15:0] s);
        fetch_t e;
        e.inst = mem_word(pc) ^ s;
        e.pc   = pc;
        e.npc  = pc + 16'd1;
        exp_q.push_back(e);
    endfunction

    // Advance one clock: sample outputs at the falling edge, return at posedge+1.
    task automatic cycle(output bit loaded, output logic rd, output logic [15:0] ad);
        logic rdy;
        @(negedge clk);
        loaded = !fetch_busy;
        rd     = i_readM;
        ad     = i_address;
        rdy    = i_ready;
        @(posedge clk);
        #1;
        if (rd && !rdy) wait_cnt++;
        else            wait_cnt = 0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; PCWrite = 1'b0; IFIDWrite = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 16'h0000;
        mem_lat = 0; wait_cnt = 0; salt = 16'h0000;
        #1;
        checks++;
        if (IFID_valid !== 1'b0 || IFID_inst !== 16'h0 || IFID_pc !== 16'h0 ||
            IFID_next_pc !== 16'h0 || num_fetch !== 16'h0) begin
            errors++;
            $display("FAIL reset_ifid: valid=%b inst=%h pc=%h npc=%h num=%h, required all zero",
                     IFID_valid, IFID_inst, IFID_pc, IFID_next_pc, num_fetch);
        end
        checks++;
        if (i_readM !== 1'b1 || i_address !== 16'h0000) begin
            errors++;
            $display("FAIL reset_req: readM=%b addr=%h, required 1 0000", i_readM, i_address);
        end
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_stream;
        bit ld; logic rd; logic [15:0] ad; fetch_t e;
        for (int p = 0; p < 4; p++) push_exp(p[15:0], salt);
        for (int k = 0; k < 4; k++) begin
            cycle(ld, rd, ad);
            checks++;
            if (!ld || rd !== 1'b1 || ad !== exp_q[0].pc) begin
                errors++;
                $display("FAIL stream_req: loaded=%0d readM=%b addr=%h, required 1 1 %h", ld, rd, ad, exp_q[0].pc);
            end
            if (ld) begin
                e = exp_q.pop_front(); exp_cnt++; last_exp = e;
                checks++;
                if (IFID_valid !== 1'b1 || IFID_pc !== e.pc || IFID_inst !== e.inst || IFID_next_pc !== e.npc) begin
                    errors++;
                    $display("FAIL stream_ifid: valid=%b pc=%h inst=%h npc=%h, required 1 %h %h %h",
                             IFID_valid, IFID_pc, IFID_inst, IFID_next_pc, e.pc, e.inst, e.npc);
                end
                $display("stream fetch pc=%h inst=%h", IFID_pc, IFID_inst);
            end
        end
        checks++;
        if (num_fetch !== 16'd4) begin
            errors++;
            $display("FAIL stream_count: num_fetch=%0d, required 4", num_fetch);
        end
    endtask

    task automatic test_latency;
        bit ld; logic rd; logic [15:0] ad; fetch_t e;
        mem_lat = 1;
        for (int p = 4; p < 7; p++) push_exp(p[15:0], salt);
        for (int k = 0; k < 6; k++) begin
            cycle(ld, rd, ad);
            checks++;
            if (ld !== bit'(k % 2) || rd !== 1'b1 || ad !== exp_q[0].pc) begin
                errors++;
                $display("FAIL latency_req: cyc=%0d loaded=%0d readM=%b addr=%h, required %0d 1 %h",
                         k, ld, rd, ad, k % 2, exp_q[0].pc);
            end
            if (ld) begin
                e = exp_q.pop_front(); exp_cnt++; last_exp = e;
                checks++;
                if (IFID_valid !== 1'b1 || IFID_pc !== e.pc || IFID_inst !== e.inst || IFID_next_pc !== e.npc) begin
                    errors++;
                    $display("FAIL latency_ifid: valid=%b pc=%h inst=%h, required 1 %h %h",
                             IFID_valid, IFID_pc, IFID_inst, e.pc, e.inst);
                end
                $display("latency fetch pc=%h inst=%h", IFID_pc, IFID_inst);
            end else begin
                checks++;
                if (IFID_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL latency_bubble: valid=%b, required 0", IFID_valid);
                end
            end
        end
        mem_lat = 0;
    endtask

    task automatic test_hold;
        bit ld; logic rd; logic [15:0] ad; fetch_t e;
        PCWrite = 1'b1; IFIDWrite = 1'b1;
        push_exp(16'h0007, salt);
        for (int k = 0; k < 3; k++) begin
            cycle(ld, rd, ad);
            salt = 16'hFFFF;  // memory content changes; the parked word must not
            checks++;
            if (ld || (k > 0 && rd !== 1'b0) || IFID_pc !== last_exp.pc ||
                IFID_inst !== last_exp.inst || IFID_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_frozen: cyc=%0d loaded=%0d readM=%b pc=%h inst=%h valid=%b, required 0 0 %h %h 1",
                         k, ld, rd, IFID_pc, IFID_inst, IFID_valid, last_exp.pc, last_exp.inst);
            end
            $display("hold cycle %0d readM=%b", k, rd);
        end
        PCWrite = 1'b0; IFIDWrite = 1'b0;
        cycle(ld, rd, ad);
        salt = 16'h0000;
        checks++;
        if (!ld || rd !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: loaded=%0d readM=%b, required 1 0", ld, rd);
        end
        if (ld) begin
            e = exp_q.pop_front(); exp_cnt++; last_exp = e;
            checks++;
            if (IFID_valid !== 1'b1 || IFID_pc !== e.pc || IFID_inst !== e.inst || IFID_next_pc !== e.npc) begin
                errors++;
                $display("FAIL hold_ifid: pc=%h inst=%h npc=%h, required %h %h %h",
                         IFID_pc, IFID_inst, IFID_next_pc, e.pc, e.inst, e.npc);
            end
        end
        checks++;
        if (i_address !== 16'h0008 || i_readM !== 1'b1) begin
            errors++;
            $display("FAIL hold_next_addr: addr=%h readM=%b, required 0008 1", i_address, i_readM);
        end
        $display("hold released pc=%h inst=%h", IFID_pc, IFID_inst);
    endtask

    task automatic test_redirect_drain;
        bit ld; logic rd; logic [15:0] ad; fetch_t e;
        // Redirect with data ready: straight back to a request at 0x0010.
        redirect_valid = 1'b1; redirect_pc = 16'h0010;
        cycle(ld, rd, ad);
        redirect_valid = 1'b0;
        checks++;
        if (ld || IFID_valid !== 1'b0 || i_address !== 16'h0010 || num_fetch !== exp_cnt[15:0]) begin
            errors++;
            $display("FAIL redir_ready: loaded=%0d valid=%b addr=%h num=%0d, required 0 0 0010 %0d",
                     ld, IFID_valid, i_address, num_fetch, exp_cnt);
        end
        mem_lat = 1000;
        cycle(ld, rd, ad);
        redirect_valid = 1'b1; redirect_pc = 16'h0040;
        cycle(ld, rd, ad);
        redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) mem_lat = 0;  // stale response finally arrives
            cycle(ld, rd, ad);
            checks++;
            if (ld || rd !== 1'b1 || ad !== 16'h0010 || IFID_valid !== 1'b0) begin
                errors++;
                $display("FAIL drain_stale: cyc=%0d loaded=%0d readM=%b addr=%h valid=%b, required 0 1 0010 0",
                         k, ld, rd, ad, IFID_valid);
            end
            $display("drain cycle %0d addr=%h", k, ad);
        end
        checks++;
        if (i_address !== 16'h0040 || num_fetch !== exp_cnt[15:0]) begin
            errors++;
            $display("FAIL drain_retarget: addr=%h num=%0d, required 0040 %0d", i_address, num_fetch, exp_cnt);
        end
        push_exp(16'h0040, salt);
        cycle(ld, rd, ad);
        checks++;
        if (!ld) begin
            errors++;
            $display("FAIL redir_fetch: loaded=%0d, required 1", ld);
        end else begin
            e = exp_q.pop_front(); exp_cnt++; last_exp = e;
            if (IFID_valid !== 1'b1 || IFID_pc !== e.pc || IFID_inst !== e.inst) begin
                errors++;
                $display("FAIL redir_fetch: pc=%h inst=%h, required %h %h", IFID_pc, IFID_inst, e.pc, e.inst);
            end
        end
        $display("redirect fetch pc=%h", IFID_pc);
    endtask

    task automatic test_redirect_hold_wrap;
        bit ld; logic rd; logic [15:0] ad; fetch_t e;
        PCWrite = 1'b1; IFIDWrite = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
        cycle(ld, rd, ad);
        PCWrite = 1'b0; IFIDWrite = 1'b0; redirect_valid = 1'b0;
        checks++;
        if (ld || IFID_valid !== 1'b0 || num_fetch !== exp_cnt[15:0] || i_address !== 16'hFFFF) begin
            errors++;
            $display("FAIL flush_wins: loaded=%0d valid=%b num=%0d addr=%h, required 0 0 %0d ffff",
                     ld, IFID_valid, num_fetch, exp_cnt, i_address);
        end
        push_exp(16'hFFFF, salt);
        push_exp(16'h0000, salt);
        for (int k = 0; k < 2; k++) begin
            cycle(ld, rd, ad);
            checks++;
            if (!ld || exp_q.size() == 0) begin
                errors++;
                $display("FAIL wrap_fetch: loaded=%0d pending=%0d, required 1", ld, exp_q.size());
            end else begin
                e = exp_q.pop_front(); exp_cnt++; last_exp = e;
                if (ad !== e.pc || IFID_pc !== e.pc || IFID_next_pc !== e.npc || IFID_inst !== e.inst) begin
                    errors++;
                    $display("FAIL wrap_fetch: addr=%h pc=%h npc=%h inst=%h, required %h %h %h %h",
                             ad, IFID_pc, IFID_next_pc, IFID_inst, e.pc, e.pc, e.npc, e.inst);
                end
            end
            $display("wrap fetch pc=%h next=%h", IFID_pc, IFID_next_pc);
        end
        checks++;
        if (num_fetch !== exp_cnt[15:0]) begin
            errors++;
            $display("FAIL wrap_count: num_fetch=%0d, required %0d", num_fetch, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_wait;
        bit ld; logic rd; logic [15:0] ad; fetch_t e;
        mem_lat = 1000;
        cycle(ld, rd, ad);
        cycle(ld, rd, ad);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (IFID_valid !== 1'b0 || IFID_inst !== 16'h0 || IFID_pc !== 16'h0 || IFID_next_pc !== 16'h0 ||
            num_fetch !== 16'h0 || i_readM !== 1'b1 || i_address !== 16'h0) begin
            errors++;
            $display("FAIL midreset: valid=%b inst=%h pc=%h npc=%h num=%h readM=%b addr=%h, required 0 0 0 0 0 1 0",
                     IFID_valid, IFID_inst, IFID_pc, IFID_next_pc, num_fetch, i_readM, i_address);
        end
        exp_q.delete(); exp_cnt = 0; wait_cnt = 0; mem_lat = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        push_exp(16'h0000, salt);
        cycle(ld, rd, ad);
        checks++;
        if (!ld || rd !== 1'b1 || ad !== 16'h0000) begin
            errors++;
            $display("FAIL post_reset: loaded=%0d readM=%b addr=%h, required 1 1 0000", ld, rd, ad);
        end else begin
            e = exp_q.pop_front(); exp_cnt++;
            if (IFID_pc !== e.pc || IFID_inst !== e.inst || num_fetch !== 16'd1) begin
                errors++;
                $display("FAIL post_reset: pc=%h inst=%h num=%0d, required %h %h 1",
                         IFID_pc, IFID_inst, num_fetch, e.pc, e.inst);
            end
        end
        $display("post-reset fetch pc=%h", IFID_pc);
    endtask

    initial begin
        checks = 0; errors = 0; exp_cnt = 0;
        test_reset;
        test_stream;
        test_latency;
        test_hold;
        test_redirect_drain;
        test_redirect_hold_wrap;
        test_reset_mid_wait;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: pending=%0d, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
